// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared types and opcode constants for the RV32 multicycle control.
package mc_ctrl_pkg;

   localparam logic [6:0] OP_ALU_R  = 7'b0110011;
   localparam logic [6:0] OP_ALU_I  = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   typedef enum logic [2:0] {
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_MEM,
      ST_WB,
      ST_TRAP
   } state_t;

   // ALU register and ALU immediate forms are split because they drive different B selects.
   typedef enum logic [3:0] {
      CLS_ALU_R,
      CLS_ALU_I,
      CLS_LOAD,
      CLS_STORE,
      CLS_BRANCH,
      CLS_JAL,
      CLS_JALR,
      CLS_AUIPC,
      CLS_LUI,
      CLS_SYSTEM,
      CLS_ILLEGAL
   } op_class_t;

   typedef enum logic [1:0] {
      PC_PLUS4  = 2'd0,
      PC_IMM    = 2'd1,
      PC_RS1IMM = 2'd2
   } pc_sel_t;

   typedef enum logic [1:0] {
      WB_ALU = 2'd0,
      WB_MEM = 2'd1,
      WB_PC4 = 2'd2,
      WB_IMM = 2'd3
   } wb_sel_t;

endpackage

// File: rtl/mc_ctrl_opclass.sv
// mc_ctrl_opclass: opcode to instruction-class map, shared with the pipelined control.
module mc_ctrl_opclass
   import mc_ctrl_pkg::*;
(
   input  logic [6:0] opcode,
   output op_class_t  op_class
);

   // Unlisted opcodes (AMO included) fall into the illegal class.
   always_comb begin
      op_class = CLS_ILLEGAL;
      case (opcode)
         OP_ALU_R:  op_class = CLS_ALU_R;
         OP_ALU_I:  op_class = CLS_ALU_I;
         OP_LOAD:   op_class = CLS_LOAD;
         OP_STORE:  op_class = CLS_STORE;
         OP_BRANCH: op_class = CLS_BRANCH;
         OP_JAL:    op_class = CLS_JAL;
         OP_JALR:   op_class = CLS_JALR;
         OP_AUIPC:  op_class = CLS_AUIPC;
         OP_LUI:    op_class = CLS_LUI;
         OP_SYSTEM: op_class = CLS_SYSTEM;
         default:   op_class = CLS_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle control FSM for the RV32 core.
// Optional feature macro: MC_CTRL_ILLEGAL_TRAP_EN (adds TRAP state and the trap port).
//
// state  | meaning
// FETCH  | imem_req held until imem_ack; ack latches IR
// DECODE | one cycle for IR -> id decode to settle
// EXEC   | ALU selects for the class; branch/system/illegal-NOP retire here
// MEM    | dmem_req held until dmem_ack; store retires on ack
// WB     | register write and PC update, retire
// TRAP   | illegal instruction, sticky until rst (macro builds only)
module mc_ctrl
   import mc_ctrl_pkg::*;
#(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [6:0]           opcode,
   input  logic [2:0]           funct3,
   input  logic                 br_taken,
   output logic                 imem_req,
   input  logic                 imem_ack,
   output logic                 dmem_req,
   output logic                 dmem_we,
   input  logic                 dmem_ack,
   output logic                 ir_we,
   output logic                 pc_we,
   output logic [1:0]           pc_sel,
   output logic                 alu_a_sel,
   output logic                 alu_b_sel,
   output logic                 rf_we,
   output logic [1:0]           wb_sel,
   output logic                 instret,
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
   output logic                 trap,
`endif
   output logic [CNT_WIDTH-1:0] instret_cnt
);

   state_t               state_q, state_d;
   op_class_t            op_class;
   pc_sel_t              pc_sel_c;
   wb_sel_t              wb_sel_c;
   logic [CNT_WIDTH-1:0] instret_cnt_q, instret_cnt_d;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
   logic                 trap_c;
`endif

   // funct3 separates ECALL/EBREAK from CSR forms, but every SYSTEM op retires as a NOP here.
   logic unused_funct3;
   assign unused_funct3 = ^funct3;

   mc_ctrl_opclass u_opclass (
      .opcode   (opcode),
      .op_class (op_class)
   );

   // Next state and all datapath controls; everything is forced low while rst is high.
   always_comb begin
      state_d   = state_q;
      imem_req  = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      pc_sel_c  = PC_PLUS4;
      alu_a_sel = 1'b0;
      alu_b_sel = 1'b0;
      rf_we     = 1'b0;
      wb_sel_c  = WB_ALU;
      instret   = 1'b0;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      trap_c    = 1'b0;
`endif
      case (state_q)
         ST_FETCH: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               ir_we   = 1'b1;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: state_d = ST_EXEC;
         ST_EXEC: begin
            case (op_class)
               CLS_ALU_R: state_d = ST_WB;
               CLS_ALU_I, CLS_JALR: begin
                  alu_b_sel = 1'b1;
                  state_d   = ST_WB;
               end
               CLS_AUIPC: begin
                  alu_a_sel = 1'b1;
                  alu_b_sel = 1'b1;
                  state_d   = ST_WB;
               end
               CLS_LUI, CLS_JAL: state_d = ST_WB;
               CLS_LOAD, CLS_STORE: begin
                  alu_b_sel = 1'b1;
                  state_d   = ST_MEM;
               end
               CLS_BRANCH: begin
                  pc_we    = 1'b1;
                  pc_sel_c = br_taken ? PC_IMM : PC_PLUS4;
                  instret  = 1'b1;
                  state_d  = ST_FETCH;
               end
               CLS_SYSTEM: begin
                  pc_we   = 1'b1;
                  instret = 1'b1;
                  state_d = ST_FETCH;
               end
               default: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                  state_d = ST_TRAP;
`else
                  pc_we   = 1'b1;
                  instret = 1'b1;
                  state_d = ST_FETCH;
`endif
               end
            endcase
         end
         ST_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = (op_class == CLS_STORE);
            if (dmem_ack) begin
               if (op_class == CLS_STORE) begin
                  pc_we   = 1'b1;
                  instret = 1'b1;
                  state_d = ST_FETCH;
               end else begin
                  state_d = ST_WB;
               end
            end
         end
         ST_WB: begin
            rf_we   = 1'b1;
            pc_we   = 1'b1;
            instret = 1'b1;
            state_d = ST_FETCH;
            case (op_class)
               CLS_LOAD: wb_sel_c = WB_MEM;
               CLS_JAL: begin
                  wb_sel_c = WB_PC4;
                  pc_sel_c = PC_IMM;
               end
               CLS_JALR: begin
                  wb_sel_c = WB_PC4;
                  pc_sel_c = PC_RS1IMM;
               end
               CLS_LUI:  wb_sel_c = WB_IMM;
               default:  wb_sel_c = WB_ALU;
            endcase
         end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
         ST_TRAP: trap_c = 1'b1;
`endif
         default: state_d = ST_FETCH;
      endcase

      if (rst) begin
         imem_req  = 1'b0;
         dmem_req  = 1'b0;
         dmem_we   = 1'b0;
         ir_we     = 1'b0;
         pc_we     = 1'b0;
         pc_sel_c  = PC_PLUS4;
         alu_a_sel = 1'b0;
         alu_b_sel = 1'b0;
         rf_we     = 1'b0;
         wb_sel_c  = WB_ALU;
         instret   = 1'b0;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
         trap_c    = 1'b0;
`endif
      end
   end

   // Retire counter advances on the edge after the instret pulse and wraps naturally.
   always_comb begin
      instret_cnt_d = instret_cnt_q + CNT_WIDTH'(instret);
   end

   // State register and counter with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_FETCH;
         instret_cnt_q <= '0;
      end else begin
         state_q       <= state_d;
         instret_cnt_q <= instret_cnt_d;
      end
   end

   assign pc_sel      = pc_sel_c;
   assign wb_sel      = wb_sel_c;
   assign instret_cnt = instret_cnt_q;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
   assign trap        = trap_c;
`endif

endmodule
